sigma_delta_dac_mc: RTL and testbench

- Multi-channel first-order delta-sigma 1-bit DAC.
- Generalises the single-channel 6-bit video accumulator DAC that sits after the video generator in the MAX10 top.
- Parametrised in sample width, channel count and update-rate divider.
- Samples are double-buffered so all channels switch on a common tick; each channel drives one pin through an external RC filter.

---
 rtl/sddac_pkg.sv | 34 +++
 rtl/sddac_ch.sv | 65 ++++++
 rtl/sigma_delta_dac_mc.sv | 96 +++++++++
 tb/tb_sigma_delta_dac_mc.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sddac_pkg.sv
// Shared constants and helpers for the multi-channel delta-sigma DAC:
// default/limit widths, dither LFSR seed and taps, divider sizing function.
package sddac_pkg;

  localparam int C_W_DEF   = 6;
  localparam int C_W_MIN   = 2;
  localparam int C_W_MAX   = 16;
  localparam int C_CH_DEF  = 2;
  localparam int C_CH_MIN  = 1;
  localparam int C_CH_MAX  = 8;
  localparam int C_DIV_DEF = 11;
  localparam int C_DIV_MIN = 1;
  localparam int C_DIV_MAX = 256;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Ceiling log2, never below 1 so a divider of 1 still gets a 1-bit counter.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 17; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/sddac_ch.sv
// One delta-sigma channel: shadow/active sample pair, first-order
// accumulator and the registered 1-bit density output.
module sddac_ch
  import sddac_pkg::*;
#(
  parameter int C_W = C_W_DEF
) (
  input  logic           CK_i,
  input  logic           XARST_i,
  input  logic           tick_i,
  input  logic           xfer_i,
  input  logic           ld_i,
  input  logic           ena_i,
  input  logic           cin_i,
  input  logic [C_W-1:0] sample_i,
  output logic           dac_o
);

  logic [C_W-1:0] shadow_q, shadow_d;
  logic [C_W-1:0] active_q, active_d;
  logic [C_W-1:0] acc_q, acc_d;
  logic           dac_q, dac_d;
  logic [C_W:0]   sum;

  assign sum = {1'b0, acc_q} + {1'b0, active_q} + {{C_W{1'b0}}, cin_i};

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    acc_d    = acc_q;
    dac_d    = dac_q;
    if (ld_i) shadow_d = sample_i;
    // active_q (pre-transfer) feeds the sum, so a new sample lands one tick later
    if (xfer_i) active_d = shadow_q;
    if (!ena_i) begin
      acc_d = '0;
      dac_d = 1'b0;
    end else if (tick_i) begin
      if (active_q == '0) begin
        acc_d = '0;
        dac_d = 1'b0;
      end else begin
        acc_d = sum[C_W-1:0];
        dac_d = sum[C_W];
      end
    end
  end

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      shadow_q <= '0;
      active_q <= '0;
      acc_q    <= '0;
      dac_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      acc_q    <= acc_d;
      dac_q    <= dac_d;
    end
  end

  assign dac_o = dac_q;

endmodule

// File: rtl/sigma_delta_dac_mc.sv
// Multi-channel first-order delta-sigma 1-bit DAC: shared update divider,
// pending flag and optional LFSR dither (SIGMA_DELTA_DAC_MC_DITHER_EN).
module sigma_delta_dac_mc
  import sddac_pkg::*;
#(
  parameter int C_W   = C_W_DEF,
  parameter int C_CH  = C_CH_DEF,
  parameter int C_DIV = C_DIV_DEF
) (
  input  logic              CK_i,
  input  logic              XARST_i,
  input  logic              ENA_i,
  input  logic              LD_i,
  input  logic [C_CH*C_W-1:0] DATs_i,
  output logic              TICK_o,
  output logic              PEND_o,
  output logic [C_CH-1:0]   DACs_o
);

  localparam int DW = clog2(C_DIV);
  localparam logic [DW-1:0] DCTR_MAX = DW'(C_DIV - 1);

  if (C_W < C_W_MIN || C_W > C_W_MAX) begin : g_bad_w
    $error("sigma_delta_dac_mc: C_W out of range");
  end
  if (C_CH < C_CH_MIN || C_CH > C_CH_MAX) begin : g_bad_ch
    $error("sigma_delta_dac_mc: C_CH out of range");
  end
  if (C_DIV < C_DIV_MIN || C_DIV > C_DIV_MAX) begin : g_bad_div
    $error("sigma_delta_dac_mc: C_DIV out of range");
  end

  logic [DW-1:0]   dctr_q, dctr_d;
  logic            tick_q, tick_d;
  logic            pend_q, pend_d;
  logic            xfer;
  logic [C_CH-1:0] cin;

  assign xfer = tick_q & pend_q;

  always_comb begin
    dctr_d = (dctr_q == DCTR_MAX) ? '0 : dctr_q + DW'(1);
    tick_d = (dctr_q == '0);
    pend_d = pend_q;
    // A load in the transfer cycle keeps the flag set for the sample just written
    if (LD_i)      pend_d = 1'b1;
    else if (xfer) pend_d = 1'b0;
  end

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      dctr_q <= '0;
      tick_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      dctr_q <= dctr_d;
      tick_q <= tick_d;
      pend_q <= pend_d;
    end
  end

`ifdef SIGMA_DELTA_DAC_MC_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = tick_q ? lfsr_step(lfsr_q) : lfsr_q;

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end

  for (genvar c = 0; c < C_CH; c++) begin : g_cin
    assign cin[c] = lfsr_q[c % 16];
  end
`else
  assign cin = '0;
`endif

  for (genvar c = 0; c < C_CH; c++) begin : g_ch
    sddac_ch #(.C_W(C_W)) u_ch (
      .CK_i     (CK_i),
      .XARST_i  (XARST_i),
      .tick_i   (tick_q),
      .xfer_i   (xfer),
      .ld_i     (LD_i),
      .ena_i    (ENA_i),
      .cin_i    (cin[c]),
      .sample_i (DATs_i[c*C_W +: C_W]),
      .dac_o    (DACs_o[c])
    );
  end

  assign TICK_o = tick_q;
  assign PEND_o = pend_q;

endmodule

// File: tb/tb_sigma_delta_dac_mc.sv
// Bench for sigma_delta_dac_mc (default build): per-cycle reference model
// plus directed density, enable, zero-sample and load/tick collision cases.
module tb_sigma_delta_dac_mc;

  localparam int W   = 6;
  localparam int CH  = 2;
  localparam int DIV = 11;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ena = 1'b0;
  logic            ld = 1'b0;
  logic [CH*W-1:0] dat = '0;
  logic            tick, pend;
  logic [CH-1:0]   dacs;
  logic            tick1, pend1;
  logic [0:0]      dacs1;

  always #5 clk = ~clk;

  sigma_delta_dac_mc #(.C_W(W), .C_CH(CH), .C_DIV(DIV)) dut (
    .CK_i(clk), .XARST_i(rst_n), .ENA_i(ena), .LD_i(ld), .DATs_i(dat),
    .TICK_o(tick), .PEND_o(pend), .DACs_o(dacs)
  );

  sigma_delta_dac_mc #(.C_W(W), .C_CH(1), .C_DIV(1)) dut1 (
    .CK_i(clk), .XARST_i(rst_n), .ENA_i(ena), .LD_i(ld), .DATs_i(dat[W-1:0]),
    .TICK_o(tick1), .PEND_o(pend1), .DACs_o(dacs1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: spec rules evaluated with integer arithmetic each clock.
  int            k;
  logic          m_tick, m_pend;
  int            m_sh[CH], m_act[CH], m_acc[CH];
  logic [CH-1:0] m_dac;

  always @(posedge clk or negedge rst_n) begin : mdl
    bit xfer;
    int sum;
    if (!rst_n) begin
      k = 0; m_tick = 0; m_pend = 0; m_dac = '0;
      for (int c = 0; c < CH; c++) begin m_sh[c] = 0; m_act[c] = 0; m_acc[c] = 0; end
    end else begin
      xfer = m_tick && m_pend;
      for (int c = 0; c < CH; c++) begin
        if (!ena) begin
          m_acc[c] = 0; m_dac[c] = 1'b0;
        end else if (m_tick) begin
          if (m_act[c] == 0) begin
            m_acc[c] = 0; m_dac[c] = 1'b0;
          end else begin
            sum = m_acc[c] + m_act[c];
            m_dac[c] = (sum >= (1 << W));
            m_acc[c] = sum % (1 << W);
          end
        end
        if (xfer) m_act[c] = m_sh[c];
        if (ld) m_sh[c] = int'(dat[c*W +: W]);
      end
      if (ld) m_pend = 1'b1;
      else if (xfer) m_pend = 1'b0;
      k++;
      m_tick = (((k - 1) % DIV) == 0);
    end
  end

  always @(negedge clk) begin
    if (rst_n) check("cycle", {29'd0, tick, pend, dacs}, {29'd0, m_tick, m_pend, m_dac});
  end

  logic [CH-1:0] seq[$];

  task automatic wait_tick();
    bit ok;
    ok = 0;
    for (int i = 0; i < 4*DIV; i++) begin
      @(negedge clk);
      if (tick) begin ok = 1; break; end
    end
    if (!ok) check("tick_timeout", 32'd0, 32'd1);
  endtask

  // Records the output produced by each of the next n ticks.
  task automatic observe(input int n);
    seq.delete();
    for (int i = 0; i < n; i++) begin
      wait_tick();
      @(negedge clk);
      seq.push_back(dacs);
    end
  endtask

  function automatic int ones(input int ch);
    int s = 0;
    foreach (seq[i]) s += int'(seq[i][ch]);
    return s;
  endfunction

  function automatic int first_one(input int ch);
    foreach (seq[i]) if (seq[i][ch]) return i + 1;
    return 0;
  endfunction

  task automatic load(input logic [W-1:0] s1, input logic [W-1:0] s0);
    ld = 1'b1;
    dat = {s1, s0};
    @(negedge clk);
    ld = 1'b0;
  endtask

  int cnt;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tick", {31'd0, tick}, 32'd0);
    check("rst_pend", {31'd0, pend}, 32'd0);
    check("rst_dacs", {30'd0, dacs}, 32'd0);
    check("rst_tick_div1", {31'd0, tick1}, 32'd0);
    rst_n = 1'b1;
    ena = 1'b1;

    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("div1_tick_high", {31'd0, tick1}, 32'd1);
    end

    wait_tick();
    @(negedge clk);
    check("tick_width", {31'd0, tick}, 32'd0);
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt++;
      if (tick) break;
    end
    check("tick_period", cnt, DIV);
    @(negedge clk);

    load(6'd1, 6'd32);
    wait_tick();
    observe(64);
    check("ch0_32_ones", ones(0), 32);
    check("ch0_32_first", {31'd0, seq[0][0]}, 32'd0);
    check("ch0_32_second", {31'd0, seq[1][0]}, 32'd1);
    check("ch1_1_ones", ones(1), 1);
    check("ch1_1_first_tick", first_one(1), 64);

    load(6'd63, 6'd32);
    wait_tick();
    observe(64);
    check("ch1_63_ones", ones(1), 63);
    check("ch0_32_ones_b", ones(0), 32);

    load(6'd63, 6'd0);
    wait_tick();
    wait_tick();
    @(negedge clk);
    check("zero_latency", {31'd0, dacs[0]}, 32'd0);
    observe(20);
    check("zero_stays", ones(0), 0);

    load(6'd63, 6'd32);
    wait_tick();
    observe(4);
    ena = 1'b0;
    @(negedge clk);
    check("ena_low_dacs", {30'd0, dacs}, 32'd0);
    load(6'd7, 6'd32);
    wait_tick();
    @(negedge clk);
    check("ena_low_xfer_pend", {31'd0, pend}, 32'd0);
    wait_tick();
    @(negedge clk);
    check("ena_low_hold", {30'd0, dacs}, 32'd0);
    ena = 1'b1;
    observe(64);
    check("ena_restart_first", {31'd0, seq[0][0]}, 32'd0);
    check("ena_restart_second", {31'd0, seq[1][0]}, 32'd1);
    check("ena_restart_ones", ones(0), 32);
    check("ch1_7_ones", ones(1), 7);

    load(6'd3, 6'd10);
    wait_tick();
    load(6'd5, 6'd20);
    check("coll_pend_hold", {31'd0, pend}, 32'd1);
    wait_tick();
    @(negedge clk);
    check("coll_pend_clear", {31'd0, pend}, 32'd0);
    observe(64);
    check("coll_ch0_20_ones", ones(0), 20);
    check("coll_ch1_5_ones", ones(1), 5);

    for (int i = 0; i < 1500; i++) begin
      ld = ($urandom_range(0, 15) == 0);
      dat = CH*W'($urandom);
      if ($urandom_range(0, 99) == 0) ena = ~ena;
      @(negedge clk);
    end
    ld = 1'b0;
    ena = 1'b1;
    repeat (30) @(negedge clk);

    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tick", {31'd0, tick}, 32'd0);
    check("async_rst_pend", {31'd0, pend}, 32'd0);
    check("async_rst_dacs", {30'd0, dacs}, 32'd0);
    check("async_rst_tick1", {31'd0, tick1}, 32'd0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
